// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and the MEM-stage
// load/store port. One transaction is in flight at a time. Each transaction
// runs grant, then MEM_LAT cycles of latency, then the response.
// Data accesses win over fetch. A starvation counter forces a fetch grant
// after STARVE_MAX data grants that were made while a fetch was waiting.
// Optional build macro: ARB_PERF_EN adds the perf_if_grants, perf_d_grants and
// perf_conflicts counters and their output ports.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   output logic        stall_if
`ifdef ARB_PERF_EN
   ,
   output logic [31:0] perf_if_grants,
   output logic [31:0] perf_d_grants,
   output logic [31:0] perf_conflicts
`endif
);

   localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

   state_t     state_r;
   owner_t     owner_r;
   logic [2:0] lat_cnt_r;
   logic [3:0] starve_cnt_r;
   logic       store_r;

   logic rsp_done_s;
   logic slot_free_s;
   logic if_force_s;
   logic d_win_s;
   logic if_win_s;

   // Decide whether the port can take a new access this cycle and who wins it
   always_comb begin
      rsp_done_s  = 1'b0;
      slot_free_s = 1'b0;
      if_force_s  = 1'b0;
      d_win_s     = 1'b0;
      if_win_s    = 1'b0;
      if (reset) begin
         rsp_done_s  = 1'b0;
         slot_free_s = 1'b0;
      end else begin
         // The response cycle also frees the port, so back-to-back grants can issue
         rsp_done_s  = (state_r == ST_WAIT) && (lat_cnt_r == 3'd0);
         slot_free_s = (state_r == ST_IDLE) || rsp_done_s;
      end
      if_force_s = (starve_cnt_r >= STARVE_LIM);
      d_win_s    = slot_free_s && d_req && !(if_req && if_force_s);
      if_win_s   = slot_free_s && if_req && !d_win_s;
   end

   // Grants, responses and fetch stall
   always_comb begin
      if_gnt    = if_win_s;
      d_gnt     = d_win_s;
      if_rvalid = 1'b0;
      d_rvalid  = 1'b0;
      if_rdata  = 32'h0000_0000;
      d_rdata   = 32'h0000_0000;
      if (rsp_done_s && (owner_r == OWN_IF)) begin
         if_rvalid = 1'b1;
         if_rdata  = mem_rdata;
      end else if (rsp_done_s && (owner_r == OWN_D)) begin
         d_rvalid = 1'b1;
         // A store completes with zero data
         if (store_r) begin
            d_rdata = 32'h0000_0000;
         end else begin
            d_rdata = mem_rdata;
         end
      end else begin
         if_rvalid = 1'b0;
         d_rvalid  = 1'b0;
      end
      // An abandoned fetch does not count as outstanding while reset is asserted
      stall_if = (if_req && !if_win_s) ||
                 (!reset && (state_r == ST_WAIT) && (owner_r == OWN_IF) && !if_rvalid);
   end

   // Steer the memory strobe and fields from the granted requester
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'h0000_0000;
      mem_wdata = 32'h0000_0000;
      mem_be    = 4'h0;
      if (d_win_s) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_we ? d_wdata : 32'h0000_0000;
         mem_be    = d_we ? d_be : 4'hF;
      end else if (if_win_s) begin
         mem_en    = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = if_addr;
         mem_wdata = 32'h0000_0000;
         mem_be    = 4'hF;
      end else begin
         mem_en    = 1'b0;
      end
   end

   // Transaction sequencer: IDLE until a grant, WAIT until the latency expires
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         owner_r   <= OWN_IF;
         lat_cnt_r <= 3'd0;
         store_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (d_win_s || if_win_s) begin
                  state_r   <= ST_WAIT;
                  owner_r   <= d_win_s ? OWN_D : OWN_IF;
                  lat_cnt_r <= LAT_LOAD;
                  store_r   <= d_win_s && d_we;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (lat_cnt_r != 3'd0) begin
                  lat_cnt_r <= lat_cnt_r - 3'd1;
               end else if (d_win_s || if_win_s) begin
                  state_r   <= ST_WAIT;
                  owner_r   <= d_win_s ? OWN_D : OWN_IF;
                  lat_cnt_r <= LAT_LOAD;
                  store_r   <= d_win_s && d_we;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               owner_r   <= OWN_IF;
               lat_cnt_r <= 3'd0;
               store_r   <= 1'b0;
            end
         endcase
      end
   end

   // Count data grants taken while a fetch waits; any idle fetch or fetch win clears it
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (!if_req || if_win_s) begin
         starve_cnt_r <= 4'd0;
      end else if (d_win_s && (starve_cnt_r != 4'd15)) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

`ifdef ARB_PERF_EN
   // Free-running wrapping grant and conflict counters
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_if_grants <= 32'd0;
         perf_d_grants  <= 32'd0;
         perf_conflicts <= 32'd0;
      end else begin
         perf_if_grants <= perf_if_grants + {31'd0, if_win_s};
         perf_d_grants  <= perf_d_grants + {31'd0, d_win_s};
         perf_conflicts <= perf_conflicts +
                           {31'd0, (if_win_s || d_win_s) && if_req && d_req};
      end
   end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (MEM_LAT=3, STARVE_MAX=4).
// The reference model tracks one busy slot with a completion cycle and a
// starvation count. It pushes the expected per-cycle outputs and the expected
// responses into queues, and a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
   localparam int MEM_LAT    = 3;
   localparam int STARVE_MAX = 4;
   localparam int NCYC       = 700;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0] d_be = '0;
   logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall_if;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0] mem_be;
`ifdef ARB_PERF_EN
   logic [31:0] perf_if_grants, perf_d_grants, perf_conflicts;
`endif

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .stall_if(stall_if)
`ifdef ARB_PERF_EN
      , .perf_if_grants(perf_if_grants), .perf_d_grants(perf_d_grants),
      .perf_conflicts(perf_conflicts)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct packed {
      logic [1:0]  gnt;   // {if_gnt, d_gnt}
      logic [69:0] mem;   // {en, we, addr, wdata, be}
      logic        stall;
   } cyc_t;
   typedef struct {
      int          due;
      logic [31:0] data;
   } rsp_t;

   cyc_t cq[$];
   rsp_t if_q[$];
   rsp_t d_q[$];

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s cyc=%0d got=event want=none", nm, cyc);
   endtask

   // Memory macro model: read data appears MEM_LAT cycles after the strobe, noise otherwise
   logic [31:0] lp [MEM_LAT];
   always @(posedge clk) begin
      for (int k = 0; k < MEM_LAT - 1; k++) lp[k] <= lp[k+1];
      lp[MEM_LAT-1] <= (mem_en && !mem_we) ? memf(mem_addr) : $urandom;
   end
   assign mem_rdata = lp[0];

   // Monitor: compare each cycle's outputs and every response against the queues
   always begin
      rsp_t rp;
      cyc_t r;
      @(negedge clk);
      if (cq.size() > 0) begin
         r = cq.pop_front();
         chk("grant", {126'd0, if_gnt, d_gnt}, {126'd0, r.gnt});
         chk("mem_bus", {58'd0, mem_en, mem_we, mem_addr, mem_wdata, mem_be}, {58'd0, r.mem});
         chk("stall_if", {127'd0, stall_if}, {127'd0, r.stall});
         if (if_rvalid) begin
            if (if_q.size() == 0) flag("if_rvalid_unexpected");
            else begin
               rp = if_q.pop_front();
               chk("if_rsp_cycle", 128'(cyc), 128'(rp.due));
               chk("if_rdata", {96'd0, if_rdata}, {96'd0, rp.data});
            end
         end else begin
            chk("if_rdata_idle", {96'd0, if_rdata}, 128'd0);
            if (if_q.size() > 0 && if_q[0].due <= cyc) begin
               flag("if_rvalid_missing");
               void'(if_q.pop_front());
            end
         end
         if (d_rvalid) begin
            if (d_q.size() == 0) flag("d_rvalid_unexpected");
            else begin
               rp = d_q.pop_front();
               chk("d_rsp_cycle", 128'(cyc), 128'(rp.due));
               chk("d_rdata", {96'd0, d_rdata}, {96'd0, rp.data});
            end
         end else begin
            chk("d_rdata_idle", {96'd0, d_rdata}, 128'd0);
            if (d_q.size() > 0 && d_q[0].due <= cyc) begin
               flag("d_rvalid_missing");
               void'(d_q.pop_front());
            end
         end
      end
   end

   // Stimulus and reference model
   initial begin
      bit busy = 0, own_if = 0, if_pend = 0, d_pend = 0, if_took = 0, d_took = 0;
      bit rst_now, free, if_out;
      int done_cyc = 0, starve = 0, win;
      int p_if = 0, p_d = 0, p_cf = 0;
      cyc_t rec;
      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc++;
         rst_now = (c < 3) || (c < 450 && $urandom_range(0, 59) == 0);
         // A requester holds its request until granted, then may drop or change it
         if (!if_pend || if_took) begin
            if (c >= 450 && c < 550) if_pend = 1;
            else if (c >= 550) if_pend = 0;
            else if_pend = ($urandom_range(0, 99) < 50);
            if_addr = {$urandom_range(0, 32'h3FFF), 2'b00};
         end
         if (!d_pend || d_took) begin
            if (c >= 450 && c < 550) d_pend = 1;
            else if (c >= 550) d_pend = 0;
            else d_pend = ($urandom_range(0, 99) < 50);
            d_we    = $urandom_range(0, 1);
            d_addr  = {$urandom_range(0, 32'h3FFF), 2'b00};
            d_wdata = $urandom;
            d_be    = 4'($urandom_range(0, 15));
         end
         reset  = rst_now;
         if_req = if_pend;
         d_req  = d_pend;
         if_took = 0;
         d_took  = 0;
         rec = '0;
         if (rst_now) begin
            busy = 0;
            starve = 0;
            if_q.delete();
            d_q.delete();
            rec.stall = if_pend;
            p_if = 0; p_d = 0; p_cf = 0;
         end else begin
            free   = !busy || (cyc == done_cyc);
            if_out = busy && own_if && (cyc != done_cyc);
            if (busy && cyc == done_cyc) busy = 0;
            win = 0;
            if (free && (if_pend || d_pend)) begin
               if (d_pend && !(if_pend && starve >= STARVE_MAX)) win = 2;
               else win = 1;
            end
            if (!if_pend || win == 1) starve = 0;
            else if (win == 2 && starve < 15) starve++;
            if (win != 0) begin
               busy = 1;
               done_cyc = cyc + MEM_LAT;
               if (if_pend && d_pend) p_cf++;
            end
            if (win == 1) begin
               own_if = 1; if_took = 1; p_if++;
               rec.gnt = 2'b10;
               rec.mem = {1'b1, 1'b0, if_addr, 32'd0, 4'hF};
               if_q.push_back('{due: done_cyc, data: memf(if_addr)});
            end else if (win == 2) begin
               own_if = 0; d_took = 1; p_d++;
               rec.gnt = 2'b01;
               rec.mem = d_we ? {1'b1, 1'b1, d_addr, d_wdata, d_be}
                              : {1'b1, 1'b0, d_addr, 32'd0, 4'hF};
               d_q.push_back('{due: done_cyc, data: d_we ? 32'd0 : memf(d_addr)});
            end
            rec.stall = (if_pend && win != 1) || if_out;
         end
         cq.push_back(rec);
      end
      @(posedge clk);
      #1;
      reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
      repeat (MEM_LAT + 3) @(posedge clk);
      #1;
      chk("if_q_drained", 128'(if_q.size()), 128'd0);
      chk("d_q_drained", 128'(d_q.size()), 128'd0);
`ifdef ARB_PERF_EN
      chk("perf_if_grants", {96'd0, perf_if_grants}, 128'(p_if));
      chk("perf_d_grants", {96'd0, perf_d_grants}, 128'(p_d));
      chk("perf_conflicts", {96'd0, perf_conflicts}, 128'(p_cf));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's single-port unified memory between the instruction-fetch requester and the MEM-stage load/store requester. It sits between the IFetch and data-memory stages and the memory macro. It runs a non-pipelined grant/latency/response sequence and produces the fetch stall that drives the PC enable. Data accesses have priority, and a bounded starvation counter guarantees that fetch makes forward progress.

## Interface
Parameters:
- MEM_LAT, 1: cycles from the issue cycle to valid `mem_rdata`; legal range 1..8.
- STARVE_MAX, 4: number of consecutive data grants, made while a fetch is pending, after which fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with `if_addr` stable until `if_gnt`.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  one-cycle pulse; `if_rdata` is valid.
- if_rdata  out  32  fetched word; 0 when `if_rvalid` is low.
- d_req  in  1  data request; held with all `d_*` inputs stable until `d_gnt`.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store byte enables.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  completion pulse for both loads and stores.
- d_rdata  out  32  load data; 0 for stores and when `d_rvalid` is low.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; 4'hF for fetches and loads.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after `mem_en`.
- stall_if  out  1  fetch not yet serviced; drives the PC enable low.

## Operation
- FSM states are IDLE and WAIT. Internal registers: `owner` (IF/D), `lat_cnt` (3 bits), `starve_cnt` (4 bits).
- In IDLE, if any request is present, exactly one grant asserts combinationally in that cycle.
  - `mem_en`=1 and `mem_*` are driven from the granted requester in the same cycle.
  - `owner` latches the granted requester, `lat_cnt` loads MEM_LAT-1, and the FSM moves to WAIT.
- In WAIT, no grant is issued and `mem_en`=0.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt`=0, the owner's rvalid pulses with `mem_rdata`, or with 0 for a store. The FSM then returns to IDLE in the same cycle.
  - Through that same-cycle return, a new grant may issue in the rvalid cycle (back-to-back).
- For MEM_LAT=1, WAIT lasts one cycle: grant at T, rvalid at T+1, next grant possible at T+1.
- Priority when both requests are present:
  - `d_req` wins.
  - Exception: if `starve_cnt` ≥ STARVE_MAX, `if_req` wins.
- `starve_cnt` rules:
  - Increments on each data grant while `if_req`=1, saturating at 15.
  - Clears on an IF grant or whenever `if_req`=0.
- Requests are never granted while in WAIT.
- A requester may drop or change its request in the cycle after its grant.
- `stall_if` = (`if_req` & ~`if_gnt`) | (WAIT & `owner`=IF & ~`if_rvalid`).
- When idle, all `mem_*` outputs are 0.

## Timing
- Reset values:
  - FSM=IDLE, `owner`=IF, `lat_cnt`=0, `starve_cnt`=0.
  - All grant, rvalid, rdata and `mem_*` outputs are 0.
  - `stall_if` is 0, or equal to `if_req` as the stall equation gives.
- Reset while in WAIT abandons the in-flight transaction: no rvalid is emitted, ever. The transaction is re-requested by its owner.
- Reset has priority over grant; no grant is issued in a reset cycle.
- Access latency: grant to rvalid is exactly MEM_LAT cycles.
- Maximum fetch wait under continuous data traffic: STARVE_MAX·MEM_LAT cycles plus the in-flight transaction.
- Simultaneous events:
  - rvalid and a new grant can occur in the same cycle, for different or the same requester.
  - `if_req` dropping in the same cycle as `starve_cnt` reaches its threshold clears the counter.

## Configuration
- ARB_PERF_EN defined:
  - Adds three outputs, each 32 bits and wrapping: `perf_if_grants`, `perf_d_grants`, `perf_conflicts`.
  - `perf_conflicts` counts cycles in which a grant is issued while both requests are present.
  - All three reset to 0.
- ARB_PERF_EN undefined: the counters and their ports are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Fetch only, MEM_LAT=1: `if_req`=1, `if_addr`=0x100, `mem_rdata`=0xDEADBEEF. Required: `if_gnt` at T, `mem_en`/`mem_addr`=0x100 at T, `if_rvalid` with `if_rdata`=0xDEADBEEF at T+1, next grant at T+1.
- Conflict, MEM_LAT=2: `if_req` and `d_req` (load 0x200) both asserted at T. Required: `d_gnt` at T, `d_rvalid` at T+2, `if_gnt` at T+2, `if_rvalid` at T+4, `stall_if`=1 through T+3.
- Store: `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678, `d_be`=4'b0011. Required: `mem_we`=1 and `mem_be`=4'b0011 on the grant cycle, `d_rvalid` after MEM_LAT cycles with `d_rdata`=0.
- Starvation, STARVE_MAX=4: `d_req` and `if_req` held continuously. Required: exactly 4 data grants, then 1 IF grant, then data grants resume with `starve_cnt` cleared.
- Reset in WAIT, MEM_LAT=3: assert `reset` one cycle after a data grant. Required: no `d_rvalid`, all outputs 0 the next cycle, a new grant possible the cycle after `reset` deasserts.
- With ARB_PERF_EN: run the starvation scenario for 10 grants. Required: `perf_d_grants`=8, `perf_if_grants`=2, `perf_conflicts`=10.
